// File: rtl/mdp_book_pkg.sv
// Shared types and constants for the book delta streamer: level layout, sides and FSM states.
package mdp_book_pkg;

    localparam int unsigned NUM_LEVELS  = 10;
    localparam int unsigned LEVEL_W     = 88;
    localparam int unsigned QTY_MSB     = 87;
    localparam int unsigned NORD_MSB    = 71;
    localparam int unsigned PRICE_MSB   = 63;
    localparam int unsigned NUM_ENTRIES = 2 * NUM_LEVELS;
    localparam int unsigned IDX_W       = $clog2(NUM_LEVELS);
    localparam int unsigned ENT_W       = $clog2(NUM_ENTRIES);

    typedef struct packed {
        logic [15:0] qty;
        logic [7:0]  num_orders;
        logic [63:0] price;
    } level_t;

    typedef enum logic {
        SIDE_BID = 1'b0,
        SIDE_ASK = 1'b1
    } side_e;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    function automatic level_t to_level(input logic [LEVEL_W-1:0] w);
        level_t l;
        l.qty        = w[QTY_MSB -: 16];
        l.num_orders = w[NORD_MSB -: 8];
        l.price      = w[PRICE_MSB -: 64];
        return l;
    endfunction

endpackage

// File: rtl/book_delta_streamer_if.sv
// Valid/ready stream carrying one changed book level per transfer.
interface book_delta_streamer_if;
    import mdp_book_pkg::*;

    logic               out_valid;
    logic               out_ready;
    logic               out_side;
    logic [IDX_W-1:0]   out_index;
    logic [LEVEL_W-1:0] out_level;
    logic               out_last;

    modport master (
        output out_valid,
        output out_side,
        output out_index,
        output out_level,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_side,
        input  out_index,
        input  out_level,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/book_change_pick.sv
// Priority encoder over the change mask: lowest set bit wins, so bids precede asks.
module book_change_pick
    import mdp_book_pkg::*;
(
    input  logic [NUM_ENTRIES-1:0] mask_i,
    output logic                   found_o,
    output logic [ENT_W-1:0]       index_o,
    output logic                   single_o
);

    always_comb begin
        found_o = 1'b0;
        index_o = '0;
        for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                found_o = 1'b1;
                index_o = ENT_W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves zero only when exactly one bit was set.
    assign single_o = found_o && ((mask_i & (mask_i - NUM_ENTRIES'(1))) == '0);

endmodule

// File: rtl/book_delta_streamer.sv
// Publishes only the book levels that differ from the last published image, one per transfer.
module book_delta_streamer
    import mdp_book_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          orderbook_ready,
    input  logic [NUM_LEVELS*LEVEL_W-1:0] bid_levels,
    input  logic [NUM_LEVELS*LEVEL_W-1:0] ask_levels,
    book_delta_streamer_if.master         stream,
    output logic                          busy,
    output logic [CNT_W-1:0]              resync_count
);

    state_e                 state_q, state_d;
    logic [NUM_ENTRIES-1:0] mask_q, mask_d;
    logic                   pending_q, pending_d;
    logic [CNT_W-1:0]       resync_q, resync_d;
    level_t                 snap_q   [NUM_ENTRIES];
    level_t                 shadow_q [NUM_ENTRIES];
    level_t                 live     [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] diff;
    logic                   capture, accept;
    logic                   pick_found, pick_single, valid;
    logic [ENT_W-1:0]       pick_idx;

    always_comb begin
        for (int i = 0; i < int'(NUM_LEVELS); i++) begin
            live[i]              = to_level(bid_levels[i*LEVEL_W +: LEVEL_W]);
            live[i + NUM_LEVELS] = to_level(ask_levels[i*LEVEL_W +: LEVEL_W]);
        end
    end

    always_comb begin
        diff = '0;
        for (int k = 0; k < int'(NUM_ENTRIES); k++) begin
            diff[k] = (live[k] != shadow_q[k]);
        end
    end

    book_change_pick u_pick (
        .mask_i   (mask_q),
        .found_o  (pick_found),
        .index_o  (pick_idx),
        .single_o (pick_single)
    );

    assign valid = (state_q == SCAN) && pick_found;

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        pending_d = pending_q;
        resync_d  = resync_q;
        capture   = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (orderbook_ready || pending_q) begin
                    capture   = 1'b1;
                    pending_d = 1'b0;
                    mask_d    = diff;
                    if (diff != '0) state_d = SCAN;
                end
            end
            SCAN: begin
                // Updates arriving mid-scan coalesce into one recapture once drained.
                if (orderbook_ready) begin
                    pending_d = 1'b1;
                    if (resync_q != '1) resync_d = resync_q + CNT_W'(1);
                end
                if (valid && stream.out_ready) begin
                    accept           = 1'b1;
                    mask_d[pick_idx] = 1'b0;
                    if (pick_single) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            pending_q <= 1'b0;
            resync_q  <= '0;
            for (int k = 0; k < int'(NUM_ENTRIES); k++) shadow_q[k] <= '0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            pending_q <= pending_d;
            resync_q  <= resync_d;
            if (accept) shadow_q[pick_idx] <= snap_q[pick_idx];
        end
    end

    // Snapshot is only read while scanning, which always follows a capture.
    always_ff @(posedge clk) begin
        if (capture) snap_q <= live;
    end

    always_comb begin
        stream.out_valid = valid;
        stream.out_side  = valid && (pick_idx >= ENT_W'(NUM_LEVELS));
        stream.out_index = '0;
        stream.out_level = '0;
        stream.out_last  = valid && pick_single;
        if (valid) begin
            stream.out_index = stream.out_side ? IDX_W'(pick_idx - ENT_W'(NUM_LEVELS))
                                               : IDX_W'(pick_idx);
            stream.out_level = snap_q[pick_idx];
        end
    end

    assign busy         = (state_q != IDLE);
    assign resync_count = resync_q;

endmodule

// File: tb/tb_book_delta_streamer.sv
// Self-checking bench: scenario tasks plus randomized rounds against a list-based delta model.
module tb_book_delta_streamer;
    import mdp_book_pkg::*;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned EW    = 1 + IDX_W + LEVEL_W + 1;

    logic                          clk = 1'b0;
    logic                          reset;
    logic                          orderbook_ready;
    logic [NUM_LEVELS*LEVEL_W-1:0] bid_levels, ask_levels;
    logic                          busy;
    logic [CNT_W-1:0]              resync_count;

    book_delta_streamer_if sif ();

    book_delta_streamer #(.CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .orderbook_ready (orderbook_ready),
        .bid_levels      (bid_levels),
        .ask_levels      (ask_levels),
        .stream          (sif),
        .busy            (busy),
        .resync_count    (resync_count)
    );

    always #5 clk = ~clk;

    logic [LEVEL_W-1:0] bid   [NUM_LEVELS];
    logic [LEVEL_W-1:0] ask   [NUM_LEVELS];
    logic [LEVEL_W-1:0] shd   [NUM_ENTRIES];
    logic [LEVEL_W-1:0] msnap [NUM_ENTRIES];
    logic [EW-1:0]      exp_q [$];
    logic [EW-1:0]      got_q [$];
    int                 checks = 0;
    int                 errors = 0;
    int                 exp_resync = 0;

    always_comb begin
        for (int i = 0; i < int'(NUM_LEVELS); i++) begin
            bid_levels[i*LEVEL_W +: LEVEL_W] = bid[i];
            ask_levels[i*LEVEL_W +: LEVEL_W] = ask[i];
        end
    end

    function automatic logic [LEVEL_W-1:0] mk(input int unsigned q, input int unsigned n,
                                              input logic [63:0] p);
        logic [15:0] q16;
        logic [7:0]  n8;
        q16 = q[15:0];
        n8  = n[7:0];
        return {q16, n8, p};
    endfunction

    function automatic logic [LEVEL_W-1:0] live_at(input int k);
        return (k < int'(NUM_LEVELS)) ? bid[k] : ask[k - int'(NUM_LEVELS)];
    endfunction

    // Expected stream: every level differing from the published copy, bids first, last flagged.
    task automatic build_exp();
        logic [EW-1:0]    e;
        logic [IDX_W-1:0] idx;
        logic             side;
        exp_q.delete();
        for (int k = 0; k < int'(NUM_ENTRIES); k++) begin
            msnap[k] = live_at(k);
            if (msnap[k] !== shd[k]) begin
                side = (k >= int'(NUM_LEVELS));
                idx  = IDX_W'(k % int'(NUM_LEVELS));
                exp_q.push_back({side, idx, msnap[k], 1'b0});
            end
        end
        if (exp_q.size() > 0) begin
            e    = exp_q.pop_back();
            e[0] = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    task automatic commit();
        for (int k = 0; k < int'(NUM_ENTRIES); k++) shd[k] = msnap[k];
    endtask

    task automatic pulse();
        @(negedge clk);
        orderbook_ready = 1'b1;
        @(negedge clk);
        orderbook_ready = 1'b0;
    endtask

    task automatic drain(input int ready_pct, output int cycles, output bit tmo);
        int waited;
        waited = 0;
        cycles = 0;
        tmo    = 1'b0;
        got_q.delete();
        while (!sif.out_valid && waited < 4) begin
            @(negedge clk);
            waited++;
        end
        if (!sif.out_valid) tmo = 1'b1;
        while (sif.out_valid && cycles < 200) begin
            sif.out_ready = ($urandom_range(99) < ready_pct);
            if (sif.out_ready)
                got_q.push_back({sif.out_side, sif.out_index, sif.out_level, sif.out_last});
            cycles++;
            @(negedge clk);
        end
        if (cycles >= 200) tmo = 1'b1;
        sif.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < int'(NUM_ENTRIES); k++) shd[k] = '0;
        exp_resync = 0;
    endtask

    task automatic test_reset();
        orderbook_ready = 1'b0;
        sif.out_ready   = 1'b0;
        for (int i = 0; i < int'(NUM_LEVELS); i++) begin
            bid[i] = '0;
            ask[i] = '0;
        end
        do_reset();
        checks++;
        if ({sif.out_valid, sif.out_last, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b want 000", {sif.out_valid, sif.out_last, busy});
        end
        checks++;
        if ({sif.out_side, sif.out_index, sif.out_level} !== '0) begin
            errors++;
            $display("FAIL reset_data got %h want 0", {sif.out_side, sif.out_index, sif.out_level});
        end
        checks++;
        if (resync_count !== '0) begin
            errors++;
            $display("FAIL reset_resync got %0d want 0", resync_count);
        end
    endtask

    task automatic test_full_book();
        int bp [NUM_LEVELS] = '{11, 10, 8, 7, 6, 5, 4, 3, 2, 1};
        int ap [NUM_LEVELS] = '{1, 2, 4, 5, 6, 7, 8, 9, 10, 11};
        int cyc;
        bit tmo;
        for (int i = 0; i < int'(NUM_LEVELS); i++) begin
            bid[i] = mk(8, 8, 64'(bp[i]));
            ask[i] = mk(8, 8, 64'(ap[i]));
        end
        build_exp();
        pulse();
        checks++;
        if (sif.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_latency got %b want 1", sif.out_valid);
        end
        drain(100, cyc, tmo);
        checks++;
        if (tmo || cyc != 20) begin
            errors++;
            $display("FAIL full_cycles got %0d (timeout %0d) want 20", cyc, tmo);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL full_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL full_xfer%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL full_busy_after got %b want 0", busy);
        end
        commit();
    endtask

    task automatic test_no_change();
        pulse();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sif.out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL nochange_c%0d got valid %b busy %b want 0 0", i, sif.out_valid, busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_two_changes();
        int cyc;
        bit tmo;
        logic [EW-1:0] first_want, second_want;
        bid[2] = mk(20, 8, 8);
        ask[0] = mk(8, 8, 0);
        first_want  = {1'b0, IDX_W'(2), mk(20, 8, 8), 1'b0};
        second_want = {1'b1, IDX_W'(0), mk(8, 8, 0), 1'b1};
        build_exp();
        pulse();
        drain(100, cyc, tmo);
        checks++;
        if (tmo || got_q.size() != 2) begin
            errors++;
            $display("FAIL two_count got %0d (timeout %0d) want 2", got_q.size(), tmo);
        end
        if (got_q.size() == 2) begin
            checks++;
            if (got_q[0] !== first_want) begin
                errors++;
                $display("FAIL two_first got %h want %h", got_q[0], first_want);
            end
            checks++;
            if (got_q[1] !== second_want) begin
                errors++;
                $display("FAIL two_second got %h want %h", got_q[1], second_want);
            end
        end
        commit();
    endtask

    task automatic test_backpressure();
        logic [EW-1:0] held;
        bid[5] = mk(33, 2, 77);
        build_exp();
        sif.out_ready = 1'b0;
        pulse();
        held = {sif.out_side, sif.out_index, sif.out_level, sif.out_last};
        checks++;
        if (exp_q.size() != 1 || held !== exp_q[0]) begin
            errors++;
            $display("FAIL bp_present got %h want %h", held, exp_q[0]);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (sif.out_valid !== 1'b1 ||
                {sif.out_side, sif.out_index, sif.out_level, sif.out_last} !== held) begin
                errors++;
                $display("FAIL bp_hold%0d got valid %b data %h want 1 %h", i, sif.out_valid,
                         {sif.out_side, sif.out_index, sif.out_level, sif.out_last}, held);
            end
            @(negedge clk);
        end
        sif.out_ready = 1'b1;
        @(negedge clk);
        sif.out_ready = 1'b0;
        checks++;
        if (sif.out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_done got valid %b busy %b want 0 0", sif.out_valid, busy);
        end
        commit();
    endtask

    task automatic test_resync();
        int cyc;
        bit tmo;
        bid[0] = mk(5, 1, 100);
        bid[7] = mk(9, 3, 50);
        ask[9] = mk(1, 1, 999);
        build_exp();
        sif.out_ready = 1'b0;
        pulse();
        bid[0] = mk(6, 2, 101);
        ask[3] = mk(44, 4, 404);
        pulse();
        pulse();
        exp_resync += 2;
        checks++;
        if (resync_count !== CNT_W'(exp_resync)) begin
            errors++;
            $display("FAIL resync_count got %0d want %0d", resync_count, exp_resync);
        end
        drain(100, cyc, tmo);
        checks++;
        if (tmo || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL resync_first_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL resync_first%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        commit();
        build_exp();
        drain(100, cyc, tmo);
        checks++;
        if (tmo || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL resync_second_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL resync_second%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        commit();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sif.out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL resync_quiet%0d got valid %b busy %b want 0 0", i, sif.out_valid,
                         busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_scan();
        int cyc;
        bit tmo;
        do_reset();
        checks++;
        if (resync_count !== '0) begin
            errors++;
            $display("FAIL midrst_resync got %0d want 0", resync_count);
        end
        sif.out_ready = 1'b1;
        pulse();
        repeat (3) @(negedge clk);
        checks++;
        if (sif.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_active got %b want 1", sif.out_valid);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (sif.out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_drop got valid %b busy %b want 0 0", sif.out_valid, busy);
        end
        reset         = 1'b0;
        sif.out_ready = 1'b0;
        build_exp();
        pulse();
        drain(100, cyc, tmo);
        checks++;
        if (tmo || got_q.size() != 20) begin
            errors++;
            $display("FAIL midrst_count got %0d want 20", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL midrst_xfer%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        commit();
    endtask

    task automatic test_random();
        int cyc;
        bit tmo;
        int k;
        for (int r = 0; r < 12; r++) begin
            for (int c = $urandom_range(5); c > 0; c--) begin
                k = $urandom_range(NUM_ENTRIES - 1);
                if (k < int'(NUM_LEVELS))
                    bid[k] = mk($urandom_range(65535), $urandom_range(255), {$urandom(), $urandom()});
                else
                    ask[k - int'(NUM_LEVELS)] = mk($urandom_range(65535), $urandom_range(255),
                                                   {$urandom(), $urandom()});
            end
            build_exp();
            pulse();
            if (exp_q.size() == 0) begin
                checks++;
                if (sif.out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd%0d_idle got %b want 0", r, sif.out_valid);
                end
            end else begin
                drain($urandom_range(30, 100), cyc, tmo);
                checks++;
                if (tmo || got_q.size() != exp_q.size()) begin
                    errors++;
                    $display("FAIL rnd%0d_count got %0d want %0d", r, got_q.size(), exp_q.size());
                end
                for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                    checks++;
                    if (got_q[i] !== exp_q[i]) begin
                        errors++;
                        $display("FAIL rnd%0d_xfer%0d got %h want %h", r, i, got_q[i], exp_q[i]);
                    end
                end
            end
            commit();
        end
    endtask

    initial begin
        test_reset();
        test_full_book();
        test_no_change();
        test_two_changes();
        test_backpressure();
        test_resync();
        test_reset_mid_scan();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
